piso_serializer: RTL

- Parallel-in, serial-out transmitter, the sending end of the 4-bit shift-register datapath.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled cycle.
- Back-to-back words stream without a bubble.
- A downstream serial-in shift register consumes sout, sout_valid and last directly.

---
 rtl/piso_serializer_pkg.sv | 15 +
 rtl/piso_bit_cnt.sv | 41 ++++
 rtl/piso_serializer.sv | 110 +++++++++++
 3 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
package piso_pkg;

  // FSM encoding: one bit is enough for the two-state machine.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Bit-counter width: clog2(width), never below 1 so the counter always exists.
  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Counts bits already sent in the current word; tc flags the final bit.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over increment; otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter. A word is taken over a valid/ready
// handshake and shifted out one bit per enabled cycle.
//
// Handshake: a word transfers on a rising edge where din_valid and din_ready
// are both high. din_ready is high in IDLE, and in SHIFT only while the last
// bit is being consumed (en=1), so back-to-back words stream without a bubble.
// While din_ready is low the producer must hold din/din_valid stable.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CW       = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             en,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic [0:0]       dbg_state_o,
  output logic [CW-1:0]    dbg_cnt_o
);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_tc;
  logic [CW-1:0]    cnt;

  piso_bit_cnt #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  assign din_ready = (state_q == ST_IDLE) | ((state_q == ST_SHIFT) & cnt_tc & en);

  // Next-state, shift-register and counter control.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (din_valid) begin
          shreg_d = din;
          cnt_clr = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (en) begin
          if (cnt_tc) begin
            // Last bit consumed: reload immediately or fall back to idle.
            cnt_clr = 1'b1;
            if (din_valid) begin
              shreg_d = din;
            end else begin
              shreg_d = '0;
              state_d = ST_IDLE;
            end
          end else begin
            // Move the next bit toward the output end, zero-fill behind it.
            shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
            cnt_inc = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        shreg_d = '0;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // State and shift register; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  // Serial outputs come straight from registers, gated to zero in IDLE.
  always_comb begin
    sout_valid = (state_q == ST_SHIFT);
    last       = (state_q == ST_SHIFT) & cnt_tc;
    sout       = 1'b0;
    if (state_q == ST_SHIFT) begin
      sout = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    end
  end

  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt;

endmodule
